// File: rtl/ifu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ifu_pkg : fetch-unit state encodings and instruction constants. Rev 1.0
// ----------------------------------------------------------------------------
package ifu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_HALT = 3'd4
  } ifu_state_e;

  localparam logic [31:0] INST_EBREAK      = 32'h0010_0073;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage : ifu_pkg
`default_nettype wire

// File: rtl/ifu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ifu : single-outstanding instruction fetch FSM with PC and decode holding
//       register. Rev 1.0
// ----------------------------------------------------------------------------
module ifu
  import ifu_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  input  logic              imem_resp_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault,
  input  logic              next_pc_valid,
  input  logic [ADDR_W-1:0] next_pc,
  output logic              halt
);

  ifu_state_e        state_q;
  ifu_state_e        state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       inst_q;
  logic [ADDR_W-1:0] inst_pc_q;
  logic              fault_q;
  logic              misaligned;
  logic              accept;

  assign misaligned    = (pc_q[1:0] != 2'b00);
  assign imem_req_addr = pc_q;
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;
  assign inst_fault    = fault_q;

  always_comb begin
    state_d        = state_q;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    halt           = 1'b0;
    accept         = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        // A misaligned PC never reaches memory; it becomes a faulting NOP.
        if (misaligned) begin
          state_d = ST_HOLD;
        end else begin
          imem_req_valid = 1'b1;
          if (imem_req_ready) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_resp_valid) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          accept  = 1'b1;
          state_d = (inst_q == INST_EBREAK && !fault_q) ? ST_HALT : ST_REQ;
        end
      end
      ST_HALT: halt = 1'b1;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= RESET_PC;
      fault_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_REQ && misaligned) begin
        inst_q    <= INST_NOP;
        inst_pc_q <= pc_q;
        fault_q   <= 1'b1;
      end else if (state_q == ST_WAIT && imem_resp_valid) begin
        inst_q    <= imem_resp_err ? INST_NOP : imem_resp_data;
        inst_pc_q <= pc_q;
        fault_q   <= imem_resp_err;
      end
      if (accept) begin
        pc_q <= next_pc_valid ? next_pc : pc_q + ADDR_W'(4);
      end
    end
  end

`ifndef SYNTHESIS
  a_resp_only_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
    imem_resp_valid |-> state_q == ST_WAIT);

  a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (imem_req_valid && !imem_req_ready) |=> (imem_req_valid && $stable(imem_req_addr)));
`endif

endmodule : ifu
`default_nettype wire

// File: tb/tb_ifu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ifu : directed self-checking bench for the ifu fetch unit. Rev 1.0
// ----------------------------------------------------------------------------
module tb_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        next_pc_valid;
  logic [31:0] next_pc;
  logic        halt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifu #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_fault(inst_fault),
    .next_pc_valid(next_pc_valid), .next_pc(next_pc), .halt(halt)
  );

  // Returns at the first falling edge where a request is visible (bounded).
  task automatic wait_req(output logic ok, output logic [31:0] addr);
    ok = 1'b0;
    addr = '0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (imem_req_valid) begin
        ok = 1'b1;
        addr = imem_req_addr;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  // Called on the request cycle: request is taken, response pulses next cycle.
  task automatic respond(input logic [31:0] d, input logic e);
    @(negedge clk);
    imem_resp_valid = 1'b1;
    imem_resp_data  = d;
    imem_resp_err   = e;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    imem_resp_err   = 1'b0;
  endtask

  task automatic accept(input logic rv, input logic [31:0] tgt);
    inst_ready    = 1'b1;
    next_pc_valid = rv;
    next_pc       = tgt;
    @(negedge clk);
    inst_ready    = 1'b0;
    next_pc_valid = 1'b0;
    next_pc       = '0;
  endtask

  task automatic test_reset();
    checks++;
    if ({imem_req_valid, inst_valid, inst_fault, halt, inst, inst_pc} !==
        {4'b0000, 32'h0, RST_PC}) begin
      errors++;
      $display("FAIL reset_state: got %b %h %h required 0000 00000000 %h",
               {imem_req_valid, inst_valid, inst_fault, halt}, inst, inst_pc, RST_PC);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic ok;
    logic [31:0] a;
    wait_req(ok, a);
    checks++;
    if (!ok || a !== RST_PC) begin
      errors++;
      $display("FAIL basic_req: got ok=%b addr=%h required ok=1 addr=%h", ok, a, RST_PC);
    end
    if (ok) respond(32'h0000_0297, 1'b0);
    checks++;
    if ({inst_valid, inst_fault, inst, inst_pc} !== {2'b10, 32'h0000_0297, RST_PC}) begin
      errors++;
      $display("FAIL basic_inst: got v=%b f=%b %h @%h required v=1 f=0 00000297 @%h",
               inst_valid, inst_fault, inst, inst_pc, RST_PC);
    end
    accept(1'b0, 32'h0);
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8000_0004}) begin
      errors++;
      $display("FAIL basic_next: got v=%b addr=%h required v=1 addr=80000004",
               imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_backpressure();
    logic ok;
    logic [31:0] a;
    wait_req(ok, a);
    if (ok) respond(32'h00a0_0093, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({inst_valid, imem_req_valid, inst, inst_pc} !== {2'b10, 32'h00a0_0093, 32'h8000_0004}) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b req=%b %h @%h required v=1 req=0 00a00093 @80000004",
                 i, inst_valid, imem_req_valid, inst, inst_pc);
      end
      @(negedge clk);
    end
    accept(1'b0, 32'h0);
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8000_0008}) begin
      errors++;
      $display("FAIL bp_next: got v=%b addr=%h required v=1 addr=80000008",
               imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_redirect();
    logic ok;
    logic [31:0] a;
    wait_req(ok, a);
    if (ok) respond(32'h0000_006f, 1'b0);
    accept(1'b1, 32'h8000_0100);
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8000_0100}) begin
      errors++;
      $display("FAIL redir_addr: got v=%b addr=%h required v=1 addr=80000100",
               imem_req_valid, imem_req_addr);
    end
    respond(32'h0000_0013, 1'b0);
    accept(1'b1, 32'h8000_0102);
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL misalign_noreq: got req_valid=%b required 0", imem_req_valid);
    end
    @(negedge clk);
    checks++;
    if ({inst_valid, inst_fault, inst, inst_pc} !== {2'b11, 32'h0000_0013, 32'h8000_0102}) begin
      errors++;
      $display("FAIL misalign_inst: got v=%b f=%b %h @%h required v=1 f=1 00000013 @80000102",
               inst_valid, inst_fault, inst, inst_pc);
    end
    accept(1'b1, 32'h8000_0200);
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8000_0200}) begin
      errors++;
      $display("FAIL realign_addr: got v=%b addr=%h required v=1 addr=80000200",
               imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_mem_error();
    respond(32'hdead_beef, 1'b1);
    checks++;
    if ({inst_valid, inst_fault, inst, inst_pc} !== {2'b11, 32'h0000_0013, 32'h8000_0200}) begin
      errors++;
      $display("FAIL memerr_inst: got v=%b f=%b %h @%h required v=1 f=1 00000013 @80000200",
               inst_valid, inst_fault, inst, inst_pc);
    end
    accept(1'b0, 32'h0);
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8000_0204}) begin
      errors++;
      $display("FAIL memerr_next: got v=%b addr=%h required v=1 addr=80000204",
               imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_wrap();
    respond(32'h0000_0013, 1'b0);
    accept(1'b1, 32'hFFFF_FFFC);
    respond(32'h0000_0013, 1'b0);
    checks++;
    if ({inst_valid, inst_pc} !== {1'b1, 32'hFFFF_FFFC}) begin
      errors++;
      $display("FAIL wrap_pc: got v=%b @%h required v=1 @fffffffc", inst_valid, inst_pc);
    end
    accept(1'b0, 32'h0);
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0000_0000}) begin
      errors++;
      $display("FAIL wrap_next: got v=%b addr=%h required v=1 addr=00000000",
               imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_ebreak();
    logic ok;
    logic [31:0] a;
    logic bad;
    respond(32'h0010_0073, 1'b0);
    accept(1'b0, 32'h0);
    checks++;
    if ({halt, inst_valid, imem_req_valid} !== 3'b100) begin
      errors++;
      $display("FAIL ebreak_halt: got halt=%b v=%b req=%b required 1 0 0",
               halt, inst_valid, imem_req_valid);
    end
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (imem_req_valid || inst_valid || !halt) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL halt_quiet: got activity=%b required 0", bad);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({halt, inst_valid, imem_req_valid, inst_fault, inst, inst_pc} !== {4'b0000, 32'h0, RST_PC}) begin
      errors++;
      $display("FAIL halt_reset: got %b %h %h required 0000 00000000 %h",
               {halt, inst_valid, imem_req_valid, inst_fault}, inst, inst_pc, RST_PC);
    end
    rst_n = 1'b1;
    wait_req(ok, a);
    checks++;
    if (!ok || a !== RST_PC) begin
      errors++;
      $display("FAIL restart_addr: got ok=%b addr=%h required ok=1 addr=%h", ok, a, RST_PC);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic ok;
    logic [31:0] a;
    @(negedge clk);
    checks++;
    if ({imem_req_valid, inst_valid} !== 2'b00) begin
      errors++;
      $display("FAIL wait_idle_outs: got req=%b v=%b required 0 0", imem_req_valid, inst_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({imem_req_valid, inst_valid, halt} !== 3'b000) begin
      errors++;
      $display("FAIL midwait_reset: got req=%b v=%b halt=%b required 0 0 0",
               imem_req_valid, inst_valid, halt);
    end
    wait_req(ok, a);
    checks++;
    if (!ok || a !== RST_PC) begin
      errors++;
      $display("FAIL midwait_restart: got ok=%b addr=%h required ok=1 addr=%h", ok, a, RST_PC);
    end
    if (ok) respond(32'h0000_0297, 1'b0);
    checks++;
    if ({inst_valid, inst_fault, inst, inst_pc} !== {2'b10, 32'h0000_0297, RST_PC}) begin
      errors++;
      $display("FAIL midwait_inst: got v=%b f=%b %h @%h required v=1 f=0 00000297 @%h",
               inst_valid, inst_fault, inst, inst_pc, RST_PC);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    imem_resp_err   = 1'b0;
    inst_ready      = 1'b0;
    next_pc_valid   = 1'b0;
    next_pc         = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect();
    test_mem_error();
    test_wrap();
    test_ebreak();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ifu
`default_nettype wire
